toy_fe_ctrl: RTL and testbench

- Frontend controller; drives the stall and change-of-flow side of the PC generator.
- Arbitrates redirects from the backend (flush) and the branch predictor. Holds the redirect until the PC generator accepts it.
- Tracks outstanding fetch-queue occupancy through a credit counter and throttles fetch with fe_ctrl_stall.
- Sits between the backend/BPU and the PC generator.

---
 rtl/toy_fe_ctrl_pkg.sv | 26 ++
 rtl/toy_fe_ctrl_if.sv | 13 +
 rtl/toy_fe_ctrl_credit.sv | 39 +++
 rtl/toy_fe_ctrl.sv | 116 +++++++++++
 tb/tb_toy_fe_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/toy_fe_ctrl_pkg.sv
// Shared types and defaults for the frontend controller: state encoding,
// redirect payload and PC helpers.
package toy_fe_ctrl_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int FQ_DEPTH_DEF  = 8;
    localparam int DRAIN_CYC_DEF = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } fe_ctrl_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] tgt_pc;
        logic                  taken;
        logic [1:0]            br_type;
    } bpu_pkg;

    // Fetch is 4-byte aligned, so the low two PC bits are dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
        return pc & ~ADDR_WIDTH'(3);
    endfunction

endpackage

// File: rtl/toy_fe_ctrl_if.sv
// Change-of-flow handshake between the frontend controller (master) and the
// PC generator (slave).
interface toy_fe_ctrl_if;
    import toy_fe_ctrl_pkg::*;

    logic   chgflw_vld;
    bpu_pkg chgflw_pld;
    logic   chgflw_rdy;

    modport master (output chgflw_vld, output chgflw_pld, input chgflw_rdy);
    modport slave  (input chgflw_vld, input chgflw_pld, output chgflw_rdy);

endinterface

// File: rtl/toy_fe_ctrl_credit.sv
// Saturating fetch-queue credit counter with flush-clear and full flag.
// Latency 1 cycle; full is registered-derived, no input-to-output path.
module toy_fe_ctrl_credit #(
    parameter int FQ_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] MAX = CW'(FQ_DEPTH);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !dec && cnt_q != MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign full = (cnt_q >= MAX);

    // Hitting either rail means the fetch/decode protocol was violated upstream.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                                     !(inc && !dec && !clr && cnt_q == MAX));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                                     !(dec && !inc && !clr && cnt_q == '0));

endmodule

// File: rtl/toy_fe_ctrl.sv
// Frontend controller: arbitrates backend/BPU redirects, holds them until the
// PC generator accepts, and throttles fetch on queue credit. All outputs registered-decoded.
module toy_fe_ctrl
    import toy_fe_ctrl_pkg::*;
#(
    parameter int FQ_DEPTH  = FQ_DEPTH_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  be_redir_vld,
    input  logic [ADDR_WIDTH-1:0] be_redir_pc,
    input  logic                  bpu_redir_vld,
    input  logic [ADDR_WIDTH-1:0] bpu_redir_pc,
    input  logic                  fetch_issue,
    input  logic                  fq_deq,
    output logic                  fe_ctrl_stall,
    toy_fe_ctrl_if.master         fe_ctrl,
    output logic                  fq_flush
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    fe_ctrl_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic                  be_flag_q, be_flag_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  flush_q, flush_d;
    logic                  fq_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            tgt_q     <= '0;
            be_flag_q <= 1'b0;
            drain_q   <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            be_flag_q <= be_flag_d;
            drain_q   <= drain_d;
            flush_q   <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        be_flag_d = be_flag_q;
        drain_d   = drain_q;
        flush_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (be_redir_vld) begin
                    state_d   = REDIR;
                    tgt_d     = align_pc(be_redir_pc);
                    be_flag_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (bpu_redir_vld) begin
                    state_d   = REDIR;
                    tgt_d     = align_pc(bpu_redir_pc);
                    be_flag_d = 1'b0;
                end
            end
            REDIR: begin
                // A flush supersedes whatever redirect is still waiting.
                if (be_redir_vld) begin
                    tgt_d     = align_pc(be_redir_pc);
                    be_flag_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (fe_ctrl.chgflw_rdy) begin
                    be_flag_d = 1'b0;
                    if (be_flag_q && DRAIN_CYC > 0) begin
                        state_d = DRAIN;
                        drain_d = DW'(DRAIN_CYC - 1);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if (be_redir_vld) begin
                    state_d   = REDIR;
                    tgt_d     = align_pc(be_redir_pc);
                    be_flag_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (drain_q == '0) begin
                    state_d = RUN;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    toy_fe_ctrl_credit #(.FQ_DEPTH(FQ_DEPTH)) u_credit (
        .clk  (clk),
        .rst  (rst),
        .inc  (fetch_issue),
        .dec  (fq_deq),
        .clr  (flush_q),
        .full (fq_full)
    );

    always_comb begin
        fe_ctrl.chgflw_pld        = '0;
        fe_ctrl.chgflw_pld.tgt_pc = tgt_q;
    end

    assign fe_ctrl.chgflw_vld = (state_q == REDIR);
    assign fe_ctrl_stall      = (state_q != RUN) | fq_full;
    assign fq_flush           = flush_q;

endmodule

// File: tb/tb_toy_fe_ctrl.sv
// Directed scenarios plus constrained-random traffic checked against a
// pending-redirect / bubble / credit model of the frontend controller.
module tb_toy_fe_ctrl;
    import toy_fe_ctrl_pkg::*;

    localparam int FQ = 8;
    localparam int DC = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  be_redir_vld = 1'b0;
    logic [ADDR_WIDTH-1:0] be_redir_pc = '0;
    logic                  bpu_redir_vld = 1'b0;
    logic [ADDR_WIDTH-1:0] bpu_redir_pc = '0;
    logic                  fetch_issue = 1'b0;
    logic                  fq_deq = 1'b0;
    logic                  fe_ctrl_stall;
    logic                  fq_flush;

    toy_fe_ctrl_if fe_ctrl_bus ();

    toy_fe_ctrl #(.FQ_DEPTH(FQ), .DRAIN_CYC(DC)) dut (
        .clk           (clk),
        .rst           (rst),
        .be_redir_vld  (be_redir_vld),
        .be_redir_pc   (be_redir_pc),
        .bpu_redir_vld (bpu_redir_vld),
        .bpu_redir_pc  (bpu_redir_pc),
        .fetch_issue   (fetch_issue),
        .fq_deq        (fq_deq),
        .fe_ctrl_stall (fe_ctrl_stall),
        .fe_ctrl       (fe_ctrl_bus),
        .fq_flush      (fq_flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a redirect is either pending or not; accepted backend
    // redirects leave DC bubble cycles; credits are a clamped integer.
    bit                    m_pend, m_from_be, m_flush;
    int                    m_bub, m_cred;
    logic [ADDR_WIDTH-1:0] m_tgt;

    function automatic bit exp_stall();
        return m_pend || (m_bub > 0) || (m_cred >= FQ);
    endfunction

    task automatic cyc(input bit r, input bit be, input logic [31:0] bepc,
                       input bit bpu, input logic [31:0] bpupc,
                       input bit rdy, input bit iss, input bit deq);
        bit nf;
        rst = r; be_redir_vld = be; be_redir_pc = bepc;
        bpu_redir_vld = bpu; bpu_redir_pc = bpupc;
        fe_ctrl_bus.chgflw_rdy = rdy; fetch_issue = iss; fq_deq = deq;
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_from_be = 0; m_flush = 0; m_bub = 0; m_cred = 0; m_tgt = '0;
        end else begin
            if (m_flush) m_cred = 0;
            else begin
                m_cred = m_cred + int'(iss) - int'(deq);
                if (m_cred < 0) m_cred = 0;
                if (m_cred > FQ) m_cred = FQ;
            end
            nf = 0;
            if (m_pend) begin
                if (be) begin m_tgt = bepc; m_from_be = 1; nf = 1; end
                else if (rdy) begin m_pend = 0; m_bub = m_from_be ? DC : 0; m_from_be = 0; end
            end else if (be) begin
                m_pend = 1; m_tgt = bepc; m_from_be = 1; nf = 1; m_bub = 0;
            end else if (m_bub > 0) begin
                m_bub--;
            end else if (bpu) begin
                m_pend = 1; m_tgt = bpupc; m_from_be = 0;
            end
            m_flush = nf;
        end
        #1;
    endtask

    task automatic idle(input bit rdy = 0, input bit iss = 0, input bit deq = 0);
        cyc(0, 0, '0, 0, '0, rdy, iss, deq);
    endtask

    task automatic test_reset();
        cyc(1, 0, '0, 0, '0, 0, 0, 0);
        cyc(1, 0, '0, 0, '0, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", fe_ctrl_bus.chgflw_vld); end
        checks++; if (fe_ctrl_bus.chgflw_pld !== '0) begin errors++; $display("FAIL reset_pld got=%h exp=0", fe_ctrl_bus.chgflw_pld); end
        checks++; if (fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", fe_ctrl_stall); end
        checks++; if (fq_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", fq_flush); end
    endtask

    task automatic test_credit_full();
        for (int i = 1; i <= FQ; i++) begin
            idle(0, 1, 0);
            checks++; if (fe_ctrl_stall !== (i >= FQ)) begin errors++; $display("FAIL credit_fill[%0d] stall got=%b exp=%b", i, fe_ctrl_stall, i >= FQ); end
        end
        idle(0, 0, 1);
        checks++; if (fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL credit_deq stall got=%b exp=0", fe_ctrl_stall); end
        for (int i = 0; i < FQ - 1; i++) idle(0, 0, 1);
    endtask

    task automatic test_bpu_hold();
        cyc(0, 0, '0, 1, 32'h8000_0106, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b1 || fe_ctrl_bus.chgflw_pld.tgt_pc !== 32'h8000_0104 || fe_ctrl_stall !== 1'b1)
                begin errors++; $display("FAIL bpu_hold[%0d] vld=%b pc=%h stall=%b exp 1/80000104/1", i, fe_ctrl_bus.chgflw_vld, fe_ctrl_bus.chgflw_pld.tgt_pc, fe_ctrl_stall); end
            if (i < 2) idle();
        end
        idle(1);
        checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b0 || fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL bpu_accept vld=%b stall=%b exp 0/0", fe_ctrl_bus.chgflw_vld, fe_ctrl_stall); end
    endtask

    task automatic test_be_bpu_same();
        for (int i = 0; i < 3; i++) idle(0, 1, 0);
        cyc(0, 1, 32'h8000_2000, 1, 32'h1234_5678, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_pld.tgt_pc !== 32'h8000_2000 || fq_flush !== 1'b1)
            begin errors++; $display("FAIL be_wins pc=%h flush=%b exp 80002000/1", fe_ctrl_bus.chgflw_pld.tgt_pc, fq_flush); end
        idle();
        checks++; if (fq_flush !== 1'b0) begin errors++; $display("FAIL be_flush_pulse flush=%b exp=0", fq_flush); end
        idle(1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (fe_ctrl_stall !== (i < 2)) begin errors++; $display("FAIL be_drain[%0d] stall got=%b exp=%b", i, fe_ctrl_stall, i < 2); end
            if (i < 2) idle();
        end
        // Credit cleared by the flush: full only after a fresh FQ issues.
        for (int i = 1; i <= FQ; i++) begin
            idle(0, 1, 0);
            checks++; if (fe_ctrl_stall !== (i >= FQ)) begin errors++; $display("FAIL be_cnt_clr[%0d] stall got=%b exp=%b", i, fe_ctrl_stall, i >= FQ); end
        end
        for (int i = 0; i < FQ; i++) idle(0, 0, 1);
    endtask

    task automatic test_be_override();
        cyc(0, 0, '0, 1, 32'h100, 0, 0, 0);
        idle();
        cyc(0, 1, 32'h200, 0, '0, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b1 || fe_ctrl_bus.chgflw_pld.tgt_pc !== 32'h200 || fq_flush !== 1'b1)
            begin errors++; $display("FAIL override vld=%b pc=%h flush=%b exp 1/200/1", fe_ctrl_bus.chgflw_vld, fe_ctrl_bus.chgflw_pld.tgt_pc, fq_flush); end
        cyc(0, 0, '0, 1, 32'h300, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_pld.tgt_pc !== 32'h200 || fq_flush !== 1'b0)
            begin errors++; $display("FAIL override_bpu_ignored pc=%h flush=%b exp 200/0", fe_ctrl_bus.chgflw_pld.tgt_pc, fq_flush); end
        idle(1);
        cyc(0, 0, '0, 1, 32'h400, 0, 0, 0);
        cyc(0, 0, '0, 1, 32'h500, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b0 || fe_ctrl_stall !== 1'b0)
            begin errors++; $display("FAIL drain_bpu_ignored vld=%b stall=%b exp 0/0", fe_ctrl_bus.chgflw_vld, fe_ctrl_stall); end
        idle();
    endtask

    task automatic test_credit_balance();
        for (int i = 0; i < 5; i++) idle(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            idle(0, 1, 1);
            checks++; if (fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL balance[%0d] stall got=%b exp=0", i, fe_ctrl_stall); end
        end
        idle(0, 1, 0); idle(0, 1, 0);
        checks++; if (fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL balance_7 stall got=%b exp=0", fe_ctrl_stall); end
        idle(0, 1, 0);
        checks++; if (fe_ctrl_stall !== 1'b1) begin errors++; $display("FAIL balance_8 stall got=%b exp=1", fe_ctrl_stall); end
        cyc(0, 1, 32'h400, 0, '0, 0, 0, 0);
        idle(0, 1, 1);
        idle(1); idle(); idle();
        checks++; if (fe_ctrl_stall !== 1'b0) begin errors++; $display("FAIL flush_clears_cnt stall got=%b exp=0", fe_ctrl_stall); end
    endtask

    task automatic test_reset_mid_redir();
        for (int i = 0; i < 4; i++) idle(0, 1, 0);
        cyc(0, 1, 32'h900, 0, '0, 0, 0, 0);
        cyc(1, 1, 32'hA00, 0, '0, 0, 0, 0);
        checks++; if (fe_ctrl_bus.chgflw_vld !== 1'b0 || fq_flush !== 1'b0 || fe_ctrl_stall !== 1'b0)
            begin errors++; $display("FAIL rst_mid vld=%b flush=%b stall=%b exp 0/0/0", fe_ctrl_bus.chgflw_vld, fq_flush, fe_ctrl_stall); end
        for (int i = 1; i <= FQ; i++) idle(0, 1, 0);
        checks++; if (fe_ctrl_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_cnt stall got=%b exp=1", fe_ctrl_stall); end
        for (int i = 0; i < FQ; i++) idle(0, 0, 1);
    endtask

    task automatic test_random();
        bit r, be, bpu, rdy, iss, deq;
        logic [31:0] bepc, bpupc;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            be  = ($urandom_range(0, 99) < 8);
            bpu = ($urandom_range(0, 99) < 30);
            rdy = ($urandom_range(0, 99) < 40);
            iss = $urandom_range(0, 1); deq = $urandom_range(0, 1);
            if (m_cred >= FQ && iss && !deq) iss = 0;
            if (m_cred == 0 && deq && !iss) deq = 0;
            bepc = $urandom; bpupc = $urandom;
            cyc(r, be, bepc, bpu, bpupc, rdy, iss, deq);
            checks++; if (fe_ctrl_bus.chgflw_vld !== m_pend) begin errors++; $display("FAIL rnd_vld[%0d] got=%b exp=%b", n, fe_ctrl_bus.chgflw_vld, m_pend); end
            checks++; if (fe_ctrl_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, fe_ctrl_stall, exp_stall()); end
            checks++; if (fq_flush !== m_flush) begin errors++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", n, fq_flush, m_flush); end
            if (m_pend) begin
                checks++; if (fe_ctrl_bus.chgflw_pld !== {align_pc(m_tgt), 3'b000})
                    begin errors++; $display("FAIL rnd_pld[%0d] got=%h exp_pc=%h", n, fe_ctrl_bus.chgflw_pld, align_pc(m_tgt)); end
            end
        end
    endtask

    initial begin
        fe_ctrl_bus.chgflw_rdy = 1'b0;
        test_reset();
        test_credit_full();
        test_bpu_hold();
        test_be_bpu_same();
        test_be_override();
        test_credit_balance();
        test_reset_mid_redir();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
